// File: rtl/debug_ram_pkg.sv
// Shared definitions for the debug RAM write engine and the hex-grid viewer.
// Holds the default RAM geometry, the row/column split of an address
// (addr = {row, col}: 64 rows of 16 bytes) and the writer state type.
package debug_ram_pkg;

  localparam int unsigned DEBUG_RAM_ADDR_W = 10;
  localparam int unsigned DEBUG_RAM_DATA_W = 8;
  localparam int unsigned DEBUG_RAM_DEPTH  = 1 << DEBUG_RAM_ADDR_W;

  localparam int unsigned DEBUG_RAM_ROW_W  = 6;
  localparam int unsigned DEBUG_RAM_COL_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_FULL  = 2'd2
  } wr_state_e;

endpackage

// File: rtl/debug_ram_writer.sv
// debug_ram_writer: write-side engine for the debug RAM (port A).
// Stores a valid/ready byte stream at consecutive addresses, supports
// repositioning the write pointer and a full-RAM zero fill.
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   in_valid/in_ready/in_data   byte stream handshake (in_ready combinational)
//   set_addr_valid/set_addr     load the write pointer
//   clear_req                   start zero-fill of the whole RAM
//   ram_en_a/ram_addr_a/ram_data_a  registered RAM port A write strobe/addr/data
//   wr_ptr            next address to be written
//   wrapped           sticky: pointer has passed the last address
//   busy              clear in progress
//   clear_done        one-cycle pulse when the clear finishes
module debug_ram_writer
  import debug_ram_pkg::*;
#(
  parameter int unsigned ADDR_W         = DEBUG_RAM_ADDR_W,
  parameter int unsigned DATA_W         = DEBUG_RAM_DATA_W,
  parameter bit          STOP_WHEN_FULL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              set_addr_valid,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clear_req,
  output logic              ram_en_a,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_data_a,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic              wrapped,
  output logic              busy,
  output logic              clear_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1);

  wr_state_e         state, state_nxt;
  logic [ADDR_W-1:0] ptr_nxt;
  logic              wrapped_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic              en_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic              accept;

  // Commands in flight block data in the same cycle.
  assign in_ready = (state == ST_IDLE) & ~clear_req & ~set_addr_valid;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      wr_ptr     <= '0;
      wrapped    <= 1'b0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
      ram_en_a   <= 1'b0;
      ram_addr_a <= '0;
      ram_data_a <= '0;
    end else begin
      state      <= state_nxt;
      wr_ptr     <= ptr_nxt;
      wrapped    <= wrapped_nxt;
      busy       <= busy_nxt;
      clear_done <= done_nxt;
      ram_en_a   <= en_nxt;
      ram_addr_a <= addr_nxt;
      ram_data_a <= data_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = wr_ptr;
    wrapped_nxt = wrapped;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    en_nxt      = 1'b0;
    addr_nxt    = ram_addr_a;
    data_nxt    = ram_data_a;

    unique case (state)
      ST_CLEAR: begin
        // During the clear wr_ptr runs one ahead of the address on the port;
        // the fill ends once the last address has been presented.
        if (ram_addr_a == LAST_ADDR) begin
          state_nxt   = ST_IDLE;
          ptr_nxt     = '0;
          wrapped_nxt = 1'b0;
          busy_nxt    = 1'b0;
          done_nxt    = 1'b1;
        end else begin
          en_nxt   = 1'b1;
          addr_nxt = wr_ptr;
          data_nxt = '0;
          ptr_nxt  = wr_ptr + ONE_ADDR;
        end
      end

      default: begin  // ST_IDLE, ST_FULL
        if (clear_req) begin
          state_nxt = ST_CLEAR;
          busy_nxt  = 1'b1;
          en_nxt    = 1'b1;
          addr_nxt  = '0;
          data_nxt  = '0;
          ptr_nxt   = ONE_ADDR;
        end else if (set_addr_valid) begin
          state_nxt = ST_IDLE;
          ptr_nxt   = set_addr;
        end else if (accept) begin
          en_nxt   = 1'b1;
          addr_nxt = wr_ptr;
          data_nxt = in_data;
          ptr_nxt  = wr_ptr + ONE_ADDR;
          if (wr_ptr == LAST_ADDR) begin
            wrapped_nxt = 1'b1;
            if (STOP_WHEN_FULL) state_nxt = ST_FULL;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_debug_ram_writer.sv
module tb_debug_ram_writer;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  logic rst;
  logic in_valid;
  logic [DW-1:0] in_data;
  logic set_addr_valid;
  logic [AW-1:0] set_addr;
  logic clear_req;

  logic          rdy     [2];
  logic          en      [2];
  logic [AW-1:0] addr    [2];
  logic [DW-1:0] data    [2];
  logic [AW-1:0] ptr     [2];
  logic          wrapped [2];
  logic          busy    [2];
  logic          done    [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  debug_ram_writer #(.ADDR_W(AW), .DATA_W(DW), .STOP_WHEN_FULL(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]), .in_data(in_data),
    .set_addr_valid(set_addr_valid), .set_addr(set_addr), .clear_req(clear_req),
    .ram_en_a(en[0]), .ram_addr_a(addr[0]), .ram_data_a(data[0]), .wr_ptr(ptr[0]),
    .wrapped(wrapped[0]), .busy(busy[0]), .clear_done(done[0]));

  debug_ram_writer #(.ADDR_W(AW), .DATA_W(DW), .STOP_WHEN_FULL(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]), .in_data(in_data),
    .set_addr_valid(set_addr_valid), .set_addr(set_addr), .clear_req(clear_req),
    .ram_en_a(en[1]), .ram_addr_a(addr[1]), .ram_data_a(data[1]), .wr_ptr(ptr[1]),
    .wrapped(wrapped[1]), .busy(busy[1]), .clear_done(done[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 = accepting, 1 = clearing, 2 = stopped full.
  // m_cleared counts zero writes issued so far in the current clear.
  int m_mode[2], m_ptr[2], m_wrapped[2], m_en[2], m_addr[2], m_data[2];
  int m_busy[2], m_done[2], m_cleared[2];

  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_mode[k] = 0; m_ptr[k] = 0; m_wrapped[k] = 0; m_en[k] = 0;
        m_addr[k] = 0; m_data[k] = 0; m_busy[k] = 0; m_done[k] = 0; m_cleared[k] = 0;
      end else begin
        m_en[k]   = 0;
        m_done[k] = 0;
        if (m_mode[k] == 1) begin
          if (m_cleared[k] < DEPTH) begin
            m_en[k] = 1; m_addr[k] = m_cleared[k]; m_data[k] = 0;
            m_cleared[k]++;
          end else begin
            m_mode[k] = 0; m_busy[k] = 0; m_done[k] = 1; m_ptr[k] = 0; m_wrapped[k] = 0;
          end
        end else if (clear_req) begin
          m_mode[k] = 1; m_busy[k] = 1;
          m_en[k] = 1; m_addr[k] = 0; m_data[k] = 0; m_cleared[k] = 1;
        end else if (set_addr_valid) begin
          m_ptr[k]  = int'(set_addr);
          m_mode[k] = 0;
        end else if (m_mode[k] == 0 && in_valid) begin
          m_en[k] = 1; m_addr[k] = m_ptr[k]; m_data[k] = int'(in_data);
          if (m_ptr[k] == DEPTH - 1) begin
            m_wrapped[k] = 1;
            if (k == 1) m_mode[k] = 2;
          end
          m_ptr[k] = (m_ptr[k] + 1) % DEPTH;
        end
      end
    end
  end

  function automatic int exp_ready(int k);
    return (m_mode[k] == 0 && !clear_req && !set_addr_valid) ? 1 : 0;
  endfunction

  // Per-cycle compare of both DUTs against the model.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("dut%0d.in_ready", k), 32'(rdy[k]), 32'(exp_ready(k)));
      chk($sformatf("dut%0d.ram_en_a", k), 32'(en[k]), 32'(m_en[k]));
      if (m_en[k] != 0) begin
        chk($sformatf("dut%0d.ram_addr_a", k), 32'(addr[k]), 32'(m_addr[k]));
        chk($sformatf("dut%0d.ram_data_a", k), 32'(data[k]), 32'(m_data[k]));
      end
      chk($sformatf("dut%0d.busy", k), 32'(busy[k]), 32'(m_busy[k]));
      chk($sformatf("dut%0d.clear_done", k), 32'(done[k]), 32'(m_done[k]));
      chk($sformatf("dut%0d.wrapped", k), 32'(wrapped[k]), 32'(m_wrapped[k]));
      if (m_busy[k] == 0)
        chk($sformatf("dut%0d.wr_ptr", k), 32'(ptr[k]), 32'(m_ptr[k]));
    end
  end

  // RAM image built from DUT0's port A writes, as the real RAM would capture them.
  int image [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) image[i] = -1;
  always @(posedge clk) if (en[0] === 1'b1) image[addr[0]] = int'(data[0]);

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int zw;
    int dc;
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    set_addr_valid = 1'b0; set_addr = '0; clear_req = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    chk("reset_in_ready", 32'(rdy[0]), 32'd1);
    chk("reset_wr_ptr", 32'(ptr[0]), 32'd0);
    chk("reset_ram_en_a", 32'(en[0]), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Stream 0x00..0x0F from address 0.
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1; in_data = 8'(i);
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("stream_wr_ptr", 32'(ptr[0]), 32'd16);
    chk("stream_wrapped", 32'(wrapped[0]), 32'd0);
    chk("stream_img0", 32'(image[0]), 32'h00);
    chk("stream_img5", 32'(image[5]), 32'h05);
    chk("stream_img15", 32'(image[15]), 32'h0F);

    // set_addr together with in_valid: the byte must not be taken.
    @(posedge clk); #1;
    set_addr_valid = 1'b1; set_addr = 10'h3F0; in_valid = 1'b1; in_data = 8'hEE;
    @(negedge clk);
    chk("set_blocks_ready", 32'(rdy[0]), 32'd0);
    @(posedge clk); #1;
    set_addr_valid = 1'b0; in_data = 8'hA5;
    cyc();
    in_data = 8'h5A;
    cyc();
    in_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("set_img3f0", 32'(image[10'h3F0]), 32'hA5);
    chk("set_img3f1", 32'(image[10'h3F1]), 32'h5A);
    chk("set_wr_ptr", 32'(ptr[0]), 32'h3F2);

    // End-of-RAM: wrap (dut0) versus stop (dut1).
    @(posedge clk); #1;
    set_addr_valid = 1'b1; set_addr = 10'h3FF;
    cyc();
    set_addr_valid = 1'b0; in_valid = 1'b1; in_data = 8'h11;
    cyc();
    in_data = 8'h22;
    @(negedge clk);
    chk("full_ready_stop", 32'(rdy[1]), 32'd0);
    chk("full_ready_wrap", 32'(rdy[0]), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc();
    @(negedge clk);
    chk("wrap_wr_ptr", 32'(ptr[0]), 32'd1);
    chk("wrap_wrapped", 32'(wrapped[0]), 32'd1);
    chk("wrap_img3ff", 32'(image[10'h3FF]), 32'h11);
    chk("wrap_img000", 32'(image[0]), 32'h22);
    chk("stop_wr_ptr", 32'(ptr[1]), 32'd0);
    chk("stop_wrapped", 32'(wrapped[1]), 32'd1);
    @(posedge clk); #1;
    set_addr_valid = 1'b1; set_addr = 10'h010;
    cyc();
    set_addr_valid = 1'b0;
    @(negedge clk);
    chk("stop_resume_ready", 32'(rdy[1]), 32'd1);
    chk("stop_resume_ptr", 32'(ptr[1]), 32'h010);

    // Full clear with in_valid held high throughout.
    @(posedge clk); #1;
    clear_req = 1'b1; in_valid = 1'b1; in_data = 8'h77;
    cyc();
    clear_req = 1'b0;
    zw = 0; dc = -1;
    for (int c = 1; c <= 1100; c++) begin
      @(negedge clk);
      if (done[0] === 1'b1) begin
        dc = c;
        break;
      end
      if (en[0] === 1'b1 && busy[0] === 1'b1 && data[0] === 8'h00) zw++;
    end
    chk("clear_done_cycle", 32'(dc), 32'd1025);
    chk("clear_zero_writes", 32'(zw), 32'd1024);
    chk("clear_wr_ptr", 32'(ptr[0]), 32'd0);
    chk("clear_wrapped", 32'(wrapped[0]), 32'd0);
    chk("clear_ready_back", 32'(rdy[0]), 32'd1);
    in_valid = 1'b0;
    cyc(); cyc();
    @(negedge clk);
    chk("clear_img3f0", 32'(image[10'h3F0]), 32'h00);
    chk("clear_img3ff", 32'(image[10'h3FF]), 32'h00);

    // Reset in the middle of a clear.
    @(posedge clk); #1;
    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    repeat (299) cyc();
    rst = 1'b1;
    #1;
    chk("abort_en", 32'(en[0]), 32'd0);
    chk("abort_addr", 32'(addr[0]), 32'd0);
    chk("abort_data", 32'(data[0]), 32'd0);
    chk("abort_busy", 32'(busy[0]), 32'd0);
    chk("abort_done", 32'(done[0]), 32'd0);
    chk("abort_ptr", 32'(ptr[0]), 32'd0);
    chk("abort_wrapped", 32'(wrapped[0]), 32'd0);
    chk("abort_ready", 32'(rdy[0]), 32'd1);
    cyc();
    rst = 1'b0; in_valid = 1'b1; in_data = 8'h99;
    cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("after_abort_en", 32'(en[0]), 32'd1);
    chk("after_abort_addr", 32'(addr[0]), 32'd0);
    chk("after_abort_data", 32'(data[0]), 32'h99);
    cyc();
    @(negedge clk);
    chk("after_abort_img0", 32'(image[0]), 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/debug_ram_writer.md
# debug_ram_writer

Write-side engine for the 1 KiB debug RAM, driving port A while the VGA hex-grid viewer reads port B. It accepts a byte stream over a valid/ready handshake and writes it to consecutive addresses. It also supports repositioning the write pointer and a full-RAM clear. Address layout matches the viewer: addr = {row[5:0], col[3:0]}, giving 64 rows of 16 bytes.

## Interface
Parameters:
- ADDR_W, 10, RAM address width; depth is 2**ADDR_W.
- DATA_W, 8, byte width.
- STOP_WHEN_FULL, 0, controls end-of-RAM behaviour:
  - 0: wrap to address 0.
  - 1: stop accepting after writing the last address.

Ports:
- clk  in  1  system pixel clock, same domain as the viewer logic.
- rst  in  1  reset; asynchronous, active-high.
- in_valid  in  1  data byte offered.
- in_ready  out  1  writer can accept a byte this cycle.
- in_data  in  DATA_W  byte to store.
- set_addr_valid  in  1  load the write pointer from set_addr.
- set_addr  in  ADDR_W  new write pointer value.
- clear_req  in  1  start zero-fill of the whole RAM.
- ram_en_a  out  1  port A write strobe (en_a).
- ram_addr_a  out  ADDR_W  port A address.
- ram_data_a  out  DATA_W  port A write data.
- wr_ptr  out  ADDR_W  next address to be written.
- wrapped  out  1  sticky flag: the pointer has passed the last address.
- busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse when the clear finishes.

## Operation
- States:
  - IDLE: accepts data and commands.
  - CLEAR: zero-fill in progress.
  - FULL: entered only when STOP_WHEN_FULL=1.
- Reset: state IDLE; wr_ptr=0; wrapped=0; busy=0; clear_done=0; ram_en_a=0; ram_addr_a=0; ram_data_a=0. in_ready reads 1 while the inputs are idle.
- in_ready = (state==IDLE) & ~clear_req & ~set_addr_valid. It is combinational, so commands block data in the same cycle.
- Priority per cycle: clear_req > set_addr_valid > data accept.
- Accept (in_valid & in_ready):
  - Registered write of in_data to wr_ptr.
  - wr_ptr increments modulo depth.
- Wrap at the last address (wr_ptr = depth-1 with an accept):
  - STOP_WHEN_FULL=0: wr_ptr → 0, wrapped → 1.
  - STOP_WHEN_FULL=1: wr_ptr → 0, wrapped → 1, state → FULL, and in_ready stays 0.
- set_addr_valid in IDLE or FULL: wr_ptr ← set_addr, state → IDLE. wrapped is unchanged.
- clear_req in IDLE or FULL:
  - Enter CLEAR and set busy=1.
  - Write 0 to every address, ascending from 0, one per cycle.
  - Then wr_ptr=0, wrapped=0, state IDLE, clear_done pulse.
- In CLEAR, clear_req, set_addr_valid and in_valid are ignored, and no bytes are lost because in_ready=0.
- ram_en_a is high only for the cycles that actually write. The port has no separate write enable.

## Timing
- Data write latency:
  - Byte accepted at edge n appears on ram_en_a/ram_addr_a/ram_data_a during cycle n+1.
  - wr_ptr shows the incremented value from n+1.
- Back-to-back accepts give one write per cycle with no bubbles.
- set_addr at edge n: wr_ptr is updated from n+1. A byte accepted at n+1 is written to set_addr.
- Clear asserted at edge n:
  - busy=1 and in_ready=0 from n+1.
  - Zero writes occupy cycles n+1 .. n+depth, at addresses 0 .. depth-1.
  - clear_done=1 and busy=0 in cycle n+depth+1, and in_ready resumes then.
- Asserting rst at any time, including mid-clear, aborts immediately to the reset values. A partially cleared RAM is acceptable.
- All outputs except in_ready are registered, so no combinational path runs from inputs to the RAM port.

## Structure
- Package debug_ram_pkg holds:
  - ADDR_W/DATA_W defaults and DEBUG_RAM_DEPTH.
  - The state enum (IDLE, CLEAR, FULL).
  - The row/column field widths (6/4), shared with the viewer.
- No sub-module; a single FSM plus pointer counter. The clear counter reuses wr_ptr.

## Test plan
- Reset, then stream bytes 0x00..0x0F with in_valid held high → 16 consecutive writes at addr 0..15, one per cycle. wr_ptr=16 and wrapped=0.
- set_addr=0x3F0, then send 0xA5,0x5A:
  - Writes at 0x3F0 and 0x3F1.
  - Additionally, set_addr and in_valid high in the same cycle → in_ready=0 and no write that cycle.
- STOP_WHEN_FULL=0, start at 0x3FF, send 0x11,0x22 → writes at 0x3FF then 0x000. wrapped=1 and wr_ptr=1.
- STOP_WHEN_FULL=1, start at 0x3FF, send 0x11 → state FULL and in_ready=0. A later set_addr=0x010 restores in_ready=1.
- clear_req at cycle n:
  - 1024 zero writes over cycles n+1..n+1024.
  - clear_done pulses at n+1025 with wr_ptr=0 and wrapped=0.
  - in_valid held high throughout is not accepted until n+1025.
- Assert rst at clear cycle 300 → all outputs return to reset values immediately. The next accepted byte is written to addr 0.
